// File: rtl/fft_twiddle_ctrl.sv
// Radix-4 FFT stage/butterfly sequencer: walks every butterfly of every stage, emits the
// W1/W2/W3 twiddle exponents and a valid strobe aligned to the fft_mult_block outputs.
module fft_twiddle_ctrl #(
    parameter int S_NUM    = 5,
    parameter int ROM_LAT  = 1,
    parameter int MULT_LAT = 2
) (
    input  logic                                          iCLK,
    input  logic                                          iRESET,
    input  logic                                          iSTART,
    input  logic                                          iEN,
    output logic                                          oBUSY,
    output logic [((S_NUM > 1) ? $clog2(S_NUM) : 1)-1:0]  oSTAGE,
    output logic [2*S_NUM-3:0]                            oBFLY,
    output logic [2*S_NUM-1:0]                            oW1_ADDR,
    output logic [2*S_NUM-1:0]                            oW2_ADDR,
    output logic [2*S_NUM-1:0]                            oW3_ADDR,
    output logic                                          oADDR_VALID,
    output logic                                          oMULT_VALID,
    output logic                                          oSTAGE_END,
    output logic                                          oDONE
);

    localparam int A_BIT = 2 * S_NUM;
    localparam int B_BIT = A_BIT - 2;
    localparam int SW    = (S_NUM > 1) ? $clog2(S_NUM) : 1;
    localparam int LAT   = ROM_LAT + MULT_LAT;
    localparam int LW    = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [B_BIT-1:0] BFLY_LAST  = {B_BIT{1'b1}};
    localparam logic [SW-1:0]    STAGE_LAST = SW'(S_NUM - 1);
    localparam logic [LW-1:0]    DRAIN_LOAD = LW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q;
    logic [SW-1:0]    stage_q;
    logic [B_BIT-1:0] bfly_q;
    logic [LW-1:0]    drain_q;
    logic [LAT-1:0]   pipe_q;
    logic [LAT-1:0]   pipe_d;

    logic             addrValid;
    logic [B_BIT-1:0] mask;
    logic [A_BIT-1:0] expE;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iSTART) begin
                        state_q <= RUN;
                        stage_q <= '0;
                        bfly_q  <= '0;
                    end
                end
                RUN: begin
                    if (iEN) begin
                        if (bfly_q == BFLY_LAST) begin
                            bfly_q  <= '0;
                            drain_q <= DRAIN_LOAD;
                            state_q <= DRAIN;
                        end else begin
                            bfly_q <= bfly_q + 1'b1;
                        end
                    end
                end
                // Wait for the ROM + multiplier pipeline to empty before the next stage reads memory.
                DRAIN: begin
                    if (drain_q == '0) begin
                        if (stage_q == STAGE_LAST) begin
                            state_q <= DONE;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            state_q <= RUN;
                        end
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    stage_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addrValid = (state_q == RUN) && iEN;
    assign pipe_d    = (pipe_q << 1) | LAT'(addrValid);

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // mask = 4^(S_NUM-1-s) - 1 is simply the all-ones butterfly field shifted right by 2s.
    always_comb begin
        mask = BFLY_LAST >> (2 * stage_q);
        expE = A_BIT'(bfly_q & mask) << (2 * stage_q);
    end

    assign oW1_ADDR    = expE;
    assign oW2_ADDR    = expE << 1;
    assign oW3_ADDR    = expE + (expE << 1);
    assign oBUSY       = (state_q != IDLE);
    assign oSTAGE      = stage_q;
    assign oBFLY       = bfly_q;
    assign oADDR_VALID = addrValid;
    assign oMULT_VALID = pipe_q[LAT-1];
    assign oSTAGE_END  = (state_q == DRAIN) && (drain_q == '0);
    assign oDONE       = (state_q == DONE);

endmodule
